// File: rtl/apb_req_arbiter_if.sv
// Signal bundle between two requesters, the arbiter and the APB slave.
// master = arbiter view; slave = requesters plus APB slave (environment side).
`timescale 1ns/1ps
interface apb_req_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              req0_done;

  logic              req1_valid;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              req1_done;

  logic [DATA_W-1:0] rdata;
  logic              err;

  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    input  prdata, pready, pslverr,
    output req0_ready, req0_done, req1_ready, req1_done,
    output rdata, err,
    output paddr, psel, penable, pwrite, pwdata
  );

  modport slave (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    output prdata, pready, pslverr,
    input  req0_ready, req0_done, req1_ready, req1_done,
    input  rdata, err,
    input  paddr, psel, penable, pwrite, pwdata
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master port between two requesters,
// with a wait-state timeout that aborts transfers the slave never completes.
`timescale 1ns/1ps
module apb_req_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  apb_req_arbiter_if.master   bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t            state_reg, state_next;
  logic              grant_reg, grant_next;
  logic              last_reg, last_next;
  logic [7:0]        wait_reg, wait_next;
  logic              psel_reg, psel_next;
  logic              penable_reg, penable_next;
  logic              pwrite_reg, pwrite_next;
  logic [ADDR_W-1:0] paddr_reg, paddr_next;
  logic [DATA_W-1:0] pwdata_reg, pwdata_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              err_reg, err_next;
  logic [1:0]        ready_reg, ready_next;
  logic [1:0]        done_reg, done_next;
  logic              any_valid;
  logic              win;

  assign any_valid = bus.req0_valid | bus.req1_valid;
  // On a tie the requester that was not served last wins.
  assign win = (bus.req0_valid & bus.req1_valid) ? ~last_reg : bus.req1_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      grant_reg   <= 1'b0;
      last_reg    <= 1'b1;
      wait_reg    <= '0;
      psel_reg    <= 1'b0;
      penable_reg <= 1'b0;
      pwrite_reg  <= 1'b0;
      paddr_reg   <= '0;
      pwdata_reg  <= '0;
      rdata_reg   <= '0;
      err_reg     <= 1'b0;
      ready_reg   <= '0;
      done_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      last_reg    <= last_next;
      wait_reg    <= wait_next;
      psel_reg    <= psel_next;
      penable_reg <= penable_next;
      pwrite_reg  <= pwrite_next;
      paddr_reg   <= paddr_next;
      pwdata_reg  <= pwdata_next;
      rdata_reg   <= rdata_next;
      err_reg     <= err_next;
      ready_reg   <= ready_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    last_next    = last_reg;
    wait_next    = wait_reg;
    psel_next    = psel_reg;
    penable_next = penable_reg;
    pwrite_next  = pwrite_reg;
    paddr_next   = paddr_reg;
    pwdata_next  = pwdata_reg;
    rdata_next   = rdata_reg;
    err_next     = err_reg;
    ready_next   = '0;
    done_next    = '0;

    case (state_reg)
      IDLE: begin
        if (any_valid) begin
          state_next   = SETUP;
          grant_next   = win;
          last_next    = win;
          wait_next    = '0;
          pwrite_next  = win ? bus.req1_write : bus.req0_write;
          paddr_next   = win ? bus.req1_addr  : bus.req0_addr;
          pwdata_next  = win ? bus.req1_wdata : bus.req0_wdata;
          psel_next    = 1'b1;
          penable_next = 1'b0;
          ready_next   = win ? 2'b10 : 2'b01;
        end
      end
      SETUP: begin
        state_next   = ACCESS;
        penable_next = 1'b1;
      end
      ACCESS: begin
        if (bus.pready) begin
          state_next   = DONE;
          psel_next    = 1'b0;
          penable_next = 1'b0;
          rdata_next   = pwrite_reg ? '0 : bus.prdata;
          err_next     = bus.pslverr;
          done_next    = grant_reg ? 2'b10 : 2'b01;
        end else if (wait_reg == WAIT_LAST) begin
          state_next   = DONE;
          psel_next    = 1'b0;
          penable_next = 1'b0;
          rdata_next   = '0;
          err_next     = 1'b1;
          done_next    = grant_reg ? 2'b10 : 2'b01;
        end else begin
          wait_next = wait_reg + 8'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.req0_ready = ready_reg[0];
  assign bus.req1_ready = ready_reg[1];
  assign bus.req0_done  = done_reg[0];
  assign bus.req1_done  = done_reg[1];
  assign bus.rdata      = rdata_reg;
  assign bus.err        = err_reg;
  assign bus.paddr      = paddr_reg;
  assign bus.psel       = psel_reg;
  assign bus.penable    = penable_reg;
  assign bus.pwrite     = pwrite_reg;
  assign bus.pwdata     = pwdata_reg;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter: two requester drivers, a small APB
// slave with programmable wait states/error/stall, and a done-pulse monitor.
`timescale 1ns/1ps
module tb_apb_req_arbiter;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic clk;
  logic reset;

  apb_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_req_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  exp_t exp0[$];
  exp_t exp1[$];
  logic exp_grant[$];
  int   rcyc[2];

  // APB slave model knobs
  int   ws      = 0;
  logic stuck   = 1'b0;
  logic slv_err = 1'b0;
  int   acc_cnt = 0;
  logic [31:0] mem[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    tests_run++;
    if (got !== expv) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, expv);
    end
  endtask

  // Slave: pready rises after ws low ACCESS cycles unless stalled.
  always_comb begin
    bus.pready  = bus.psel && bus.penable && !stuck && (acc_cnt >= ws);
    bus.prdata  = mem[bus.paddr[3:2]];
    bus.pslverr = slv_err;
  end

  initial begin
    mem[0] = 32'h1111_1111;
    mem[1] = 32'h2222_2222;
    mem[2] = 32'h3333_3333;
    mem[3] = 32'h5A5A_C0C0;
  end

  always @(posedge clk) begin
    if (bus.psel && bus.penable && !bus.pready)
      acc_cnt <= acc_cnt + 1;
    else if (!(bus.psel && bus.penable))
      acc_cnt <= 0;
    if (bus.psel && bus.penable && bus.pready && bus.pwrite)
      mem[bus.paddr[3:2]] <= bus.pwdata;
  end

  // Monitor: grants, done pulses, APB stability
  initial begin
    logic        id;
    logic        prev_psel;
    logic [31:0] prev_paddr;
    logic        prev_pwrite;
    exp_t        e;
    prev_psel   = 1'b0;
    prev_paddr  = '0;
    prev_pwrite = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_psel = 1'b0;
      end else begin
        if (bus.req0_ready || bus.req1_ready) begin
          chk("ready_onehot", 32'(bus.req0_ready & bus.req1_ready), 0);
          id = bus.req1_ready;
          rcyc[id] = cyc;
          if (exp_grant.size() == 0) begin
            chk("grant_unexpected", 1, 0);
          end else begin
            chk("grant_id", 32'(id), 32'(exp_grant.pop_front()));
            $display("[TB] grant req%0d addr=0x%08h write=%0d", id, bus.paddr, bus.pwrite);
          end
        end
        if (bus.req0_done || bus.req1_done) begin
          chk("done_onehot", 32'(bus.req0_done & bus.req1_done), 0);
          id = bus.req1_done;
          if ((id ? exp1.size() : exp0.size()) == 0) begin
            chk("done_unexpected", 1, 0);
          end else begin
            e = id ? exp1.pop_front() : exp0.pop_front();
            chk("rdata", bus.rdata, e.rdata);
            chk("err", 32'(bus.err), 32'(e.err));
            chk("latency", 32'(cyc - rcyc[id]), 32'(e.lat));
            chk("psel_in_done", {30'd0, bus.psel, bus.penable}, 0);
            $display("[TB] done  req%0d rdata=0x%08h err=%0d lat=%0d", id, bus.rdata, bus.err, cyc - rcyc[id]);
          end
        end
        if (bus.penable) chk("penable_needs_psel", 32'(bus.psel), 1);
        if (bus.psel && prev_psel) begin
          chk("paddr_stable", bus.paddr, prev_paddr);
          chk("pwrite_stable", 32'(bus.pwrite), 32'(prev_pwrite));
        end
        prev_psel   = bus.psel;
        prev_paddr  = bus.paddr;
        prev_pwrite = bus.pwrite;
      end
    end
  end

  // Present one request, push its expected completion, hold until ready.
  task automatic send(input logic id, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    exp_t e;
    logic got;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.lat   = exp_lat;
    if (id) exp1.push_back(e);
    else    exp0.push_back(e);
    if (id) begin
      bus.req1_write = w; bus.req1_addr = a; bus.req1_wdata = d; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_write = w; bus.req0_addr = a; bus.req0_wdata = d; bus.req0_valid = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (id ? bus.req1_ready : bus.req0_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (id) bus.req1_valid = 1'b0;
    else    bus.req0_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic drained;
    drained = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp0.size() == 0 && exp1.size() == 0 && exp_grant.size() == 0) begin
        drained = 1'b1;
        break;
      end
    end
    if (!drained) chk("drain_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;
    reset = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_write = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
    bus.req1_valid = 1'b0; bus.req1_write = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_psel_penable", {30'd0, bus.psel, bus.penable}, 0);
    chk("rst_ready_done", {28'd0, bus.req1_ready, bus.req0_ready, bus.req1_done, bus.req0_done}, 0);
    chk("rst_pwrite_err", {30'd0, bus.pwrite, bus.err}, 0);
    chk("rst_paddr", bus.paddr, 0);
    chk("rst_pwdata", bus.pwdata, 0);
    chk("rst_rdata", bus.rdata, 0);
    reset = 1'b0;

    // Tie straight after reset: req0 first
    exp_grant.push_back(1'b0);
    exp_grant.push_back(1'b1);
    fork
      send(1'b0, 1'b1, 32'h4, 32'h1910_2025, 32'h0, 1'b0, 2);
      send(1'b1, 1'b1, 32'h8, 32'h666E_6150, 32'h0, 1'b0, 2);
    join
    wait_idle();
    exp_grant.push_back(1'b0);
    send(1'b0, 1'b0, 32'h4, 32'h0, 32'h1910_2025, 1'b0, 2);
    exp_grant.push_back(1'b1);
    send(1'b1, 1'b0, 32'h8, 32'h0, 32'h666E_6150, 1'b0, 2);
    wait_idle();

    // Single write then read-back
    exp_grant.push_back(1'b0);
    send(1'b0, 1'b1, 32'h0, 32'd9, 32'h0, 1'b0, 2);
    exp_grant.push_back(1'b0);
    send(1'b0, 1'b0, 32'h0, 32'h0, 32'd9, 1'b0, 2);
    wait_idle();

    // Three wait states then slave error on read of 0xC
    ws = 3; slv_err = 1'b1;
    exp_grant.push_back(1'b1);
    send(1'b1, 1'b0, 32'hC, 32'h0, 32'h5A5A_C0C0, 1'b1, 5);
    wait_idle();
    ws = 0; slv_err = 1'b0;

    // Alternation with both requesters continuously valid
    exp_grant.push_back(1'b0);
    exp_grant.push_back(1'b1);
    exp_grant.push_back(1'b0);
    exp_grant.push_back(1'b1);
    fork
      begin
        send(1'b0, 1'b1, 32'h0, 32'hA5A5_0001, 32'h0, 1'b0, 2);
        send(1'b0, 1'b0, 32'h0, 32'h0, 32'hA5A5_0001, 1'b0, 2);
      end
      begin
        send(1'b1, 1'b1, 32'h8, 32'h0BAD_F00D, 32'h0, 1'b0, 2);
        send(1'b1, 1'b0, 32'h8, 32'h0, 32'h0BAD_F00D, 1'b0, 2);
      end
    join
    wait_idle();

    // Timeout: 16 ACCESS cycles, then normal service resumes
    stuck = 1'b1;
    exp_grant.push_back(1'b0);
    send(1'b0, 1'b0, 32'h4, 32'h0, 32'h0, 1'b1, 17);
    wait_idle();
    stuck = 1'b0;
    exp_grant.push_back(1'b1);
    send(1'b1, 1'b0, 32'h0, 32'h0, 32'hA5A5_0001, 1'b0, 2);
    exp_grant.push_back(1'b0);
    send(1'b0, 1'b0, 32'h8, 32'h0, 32'h0BAD_F00D, 1'b0, 2);
    wait_idle();

    // Reset in the middle of a stalled ACCESS phase
    stuck = 1'b1;
    exp_grant.push_back(1'b0);
    send(1'b0, 1'b0, 32'h4, 32'h0, 32'h0, 1'b1, 17);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.penable) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("access_timeout", 0, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_psel_penable", {30'd0, bus.psel, bus.penable}, 0);
    chk("midrst_done", {30'd0, bus.req1_done, bus.req0_done}, 0);
    exp0.delete();
    exp1.delete();
    exp_grant.delete();
    stuck = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_rdata", bus.rdata, 0);
    reset = 1'b0;
    exp_grant.push_back(1'b0);
    exp_grant.push_back(1'b1);
    fork
      send(1'b0, 1'b0, 32'h4, 32'h0, 32'h1910_2025, 1'b0, 2);
      send(1'b1, 1'b0, 32'hC, 32'h0, 32'h5A5A_C0C0, 1'b0, 2);
    join
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
